// File: rtl/mux4_rr_arbiter_if.sv
// Bundle of request, data and grant signals shared by the four sources and the mux4 round-robin arbiter.
interface mux4_rr_arbiter_if;
    logic [3:0] req;
    logic [3:0] in;
    logic [3:0] gnt;
    logic [1:0] sel;
    logic       q;
    logic       valid;

    modport master (output req, in, input gnt, sel, q, valid);
    modport slave  (input req, in, output gnt, sel, q, valid);
endinterface

// File: rtl/mux4_rr_arbiter.sv
// Round-robin arbiter and select sequencer for a 4:1 single-bit mux with bounded grant hold.
// Define MUXARB_HOLD_EN to let an owner keep the grant for up to MAX_HOLD cycles; otherwise it re-arbitrates every cycle.
module mux4_rr_arbiter #(
    parameter int unsigned MAX_HOLD = 4
) (
    input  logic              clk,
    input  logic              rst,
    mux4_rr_arbiter_if.slave  bus
);

    localparam int unsigned N     = 4;
    localparam int unsigned IDX_W = 2;

`ifdef MUXARB_HOLD_EN
    localparam int unsigned CNT_W      = 4;
    localparam int unsigned HOLD_LIMIT = (MAX_HOLD < 1) ? 1 : ((MAX_HOLD > 15) ? 15 : MAX_HOLD);
`else
    // MAX_HOLD is ignored here: every grant lasts exactly one cycle.
    localparam int unsigned HOLD_LIMIT = (MAX_HOLD >= 1) ? 1 : 1;
`endif

    typedef enum logic {
        S_IDLE,
        S_GRANT
    } state_t;

    state_t             r_state;
    state_t             w_nxt_state;
    logic [N-1:0]       r_gnt;
    logic [N-1:0]       w_nxt_gnt;
    logic [IDX_W-1:0]   r_sel;
    logic [IDX_W-1:0]   w_nxt_sel;
    logic [IDX_W-1:0]   r_last;
    logic [IDX_W-1:0]   w_nxt_last;
    logic [IDX_W-1:0]   w_win;
    logic [IDX_W-1:0]   w_idx;
    logic               w_any;
    logic               w_keep;
    logic               w_valid;
`ifdef MUXARB_HOLD_EN
    logic [CNT_W-1:0]   r_cnt;
    logic [CNT_W-1:0]   w_nxt_cnt;
`endif

    // Search order last+1, last+2, last+3, last; scanning backwards lets the earliest hit win.
    always_comb begin
        w_win = '0;
        w_any = 1'b0;
        w_idx = '0;
        for (int k = N; k >= 1; k--) begin
            w_idx = r_last + IDX_W'(k);
            if (bus.req[w_idx]) begin
                w_win = w_idx;
                w_any = 1'b1;
            end
        end
    end

`ifdef MUXARB_HOLD_EN
    assign w_keep = (r_state == S_GRANT) && bus.req[r_sel] && (r_cnt < CNT_W'(HOLD_LIMIT));
`else
    assign w_keep = (r_state == S_GRANT) && bus.req[r_sel] && (HOLD_LIMIT > 1);
`endif

    // Next-state and next-grant logic; the owner index always equals r_sel while granted.
    always_comb begin
        w_nxt_state = r_state;
        w_nxt_gnt   = r_gnt;
        w_nxt_sel   = r_sel;
        w_nxt_last  = r_last;
`ifdef MUXARB_HOLD_EN
        w_nxt_cnt   = r_cnt;
`endif
        if (w_keep) begin
            w_nxt_state = S_GRANT;
`ifdef MUXARB_HOLD_EN
            w_nxt_cnt   = r_cnt + CNT_W'(1);
`endif
        end else if (w_any) begin
            w_nxt_state       = S_GRANT;
            w_nxt_gnt         = '0;
            w_nxt_gnt[w_win]  = 1'b1;
            w_nxt_sel         = w_win;
            w_nxt_last        = w_win;
`ifdef MUXARB_HOLD_EN
            w_nxt_cnt         = CNT_W'(1);
`endif
        end else begin
            w_nxt_state = S_IDLE;
            w_nxt_gnt   = '0;
`ifdef MUXARB_HOLD_EN
            w_nxt_cnt   = '0;
`endif
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_gnt   <= '0;
            r_sel   <= '0;
            r_last  <= IDX_W'(3);
`ifdef MUXARB_HOLD_EN
            r_cnt   <= '0;
`endif
        end else begin
            r_state <= w_nxt_state;
            r_gnt   <= w_nxt_gnt;
            r_sel   <= w_nxt_sel;
            r_last  <= w_nxt_last;
`ifdef MUXARB_HOLD_EN
            r_cnt   <= w_nxt_cnt;
`endif
        end
    end

    // Data is never registered: q tracks in[sel] combinationally while a grant is live.
    assign w_valid   = |r_gnt;
    assign bus.gnt   = r_gnt;
    assign bus.sel   = r_sel;
    assign bus.valid = w_valid;
    assign bus.q     = w_valid & bus.in[r_sel];

endmodule

// File: tb/tb_mux4_rr_arbiter.sv
// Directed self-checking bench for mux4_rr_arbiter; expectations adapt to MUXARB_HOLD_EN.
module tb_mux4_rr_arbiter;

`ifdef MUXARB_HOLD_EN
    localparam int unsigned H = 4;
`else
    localparam int unsigned H = 1;
`endif

    logic clk;
    logic rst;
    int   n_checks;
    int   n_fail;

    mux4_rr_arbiter_if bus ();

    mux4_rr_arbiter #(.MAX_HOLD(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst     = 1'b1;
        bus.req = 4'b0000;
        bus.in  = 4'b0000;
        tick();
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst     = 1'b1;
        bus.req = 4'b1111;
        bus.in  = 4'b1111;
        tick();
        tick();
        n_checks++; if (bus.gnt !== 4'b0000) begin n_fail++; $display("FAIL reset_gnt: got %b expected 0000", bus.gnt); end
        n_checks++; if (bus.valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b expected 0", bus.valid); end
        n_checks++; if (bus.q !== 1'b0) begin n_fail++; $display("FAIL reset_q: got %b expected 0", bus.q); end
        n_checks++; if (bus.sel !== 2'd0) begin n_fail++; $display("FAIL reset_sel: got %0d expected 0", bus.sel); end
        @(negedge clk);
        rst = 1'b0;
        tick();
        n_checks++; if (bus.gnt !== 4'b0001) begin n_fail++; $display("FAIL first_gnt: got %b expected 0001", bus.gnt); end
        n_checks++; if (bus.sel !== 2'd0) begin n_fail++; $display("FAIL first_sel: got %0d expected 0", bus.sel); end
        n_checks++; if (bus.q !== 1'b1) begin n_fail++; $display("FAIL first_q: got %b expected 1", bus.q); end
    endtask

    task automatic test_rotation();
        logic [1:0] exp_sel;
        logic [3:0] exp_gnt;
        do_reset();
        bus.req = 4'b1111;
        for (int i = 0; i < 8; i++) begin
            tick();
            exp_sel = 2'((i / H) % 4);
            exp_gnt = 4'b0001 << exp_sel;
            n_checks++; if (bus.sel !== exp_sel) begin n_fail++; $display("FAIL rotation_sel[%0d]: got %0d expected %0d", i, bus.sel, exp_sel); end
            n_checks++; if (bus.gnt !== exp_gnt) begin n_fail++; $display("FAIL rotation_gnt[%0d]: got %b expected %b", i, bus.gnt, exp_gnt); end
        end
    endtask

    task automatic test_hold_expiry();
        logic [3:0] exp_gnt;
        do_reset();
        bus.req = 4'b0011;
        for (int i = 0; i < 12; i++) begin
            tick();
            exp_gnt = (((i / H) % 2) == 0) ? 4'b0001 : 4'b0010;
            n_checks++; if (bus.gnt !== exp_gnt) begin n_fail++; $display("FAIL hold_gnt[%0d]: got %b expected %b", i, bus.gnt, exp_gnt); end
        end
    endtask

    task automatic test_early_release();
        do_reset();
        bus.req = 4'b0100;
        for (int i = 0; i < 2; i++) begin
            tick();
            n_checks++; if (bus.gnt !== 4'b0100) begin n_fail++; $display("FAIL early_own[%0d]: got %b expected 0100", i, bus.gnt); end
        end
        bus.req = 4'b1000;
        tick();
        n_checks++; if (bus.gnt !== 4'b1000) begin n_fail++; $display("FAIL early_handover_gnt: got %b expected 1000", bus.gnt); end
        n_checks++; if (bus.sel !== 2'd3) begin n_fail++; $display("FAIL early_handover_sel: got %0d expected 3", bus.sel); end
        n_checks++; if (bus.valid !== 1'b1) begin n_fail++; $display("FAIL early_handover_valid: got %b expected 1", bus.valid); end
    endtask

    task automatic test_sole_requester();
        do_reset();
        bus.req = 4'b0100;
        for (int i = 0; i < 10; i++) begin
            tick();
            n_checks++; if (bus.gnt !== 4'b0100) begin n_fail++; $display("FAIL sole_gnt[%0d]: got %b expected 0100", i, bus.gnt); end
            n_checks++; if (bus.valid !== 1'b1) begin n_fail++; $display("FAIL sole_valid[%0d]: got %b expected 1", i, bus.valid); end
        end
    endtask

    task automatic test_datapath();
        do_reset();
        bus.req = 4'b0010;
        bus.in  = 4'b0010;
        tick();
        n_checks++; if (bus.sel !== 2'd1) begin n_fail++; $display("FAIL data_sel: got %0d expected 1", bus.sel); end
        n_checks++; if (bus.q !== 1'b1) begin n_fail++; $display("FAIL data_q_one: got %b expected 1", bus.q); end
        bus.in  = 4'b1101;
        bus.req = 4'b0000;
        #1;
        n_checks++; if (bus.q !== 1'b0) begin n_fail++; $display("FAIL data_q_zero: got %b expected 0", bus.q); end
        tick();
        bus.in = 4'b1111;
        #1;
        n_checks++; if (bus.gnt !== 4'b0000) begin n_fail++; $display("FAIL idle_gnt: got %b expected 0000", bus.gnt); end
        n_checks++; if (bus.sel !== 2'd1) begin n_fail++; $display("FAIL idle_sel_kept: got %0d expected 1", bus.sel); end
        n_checks++; if (bus.valid !== 1'b0) begin n_fail++; $display("FAIL idle_valid: got %b expected 0", bus.valid); end
        n_checks++; if (bus.q !== 1'b0) begin n_fail++; $display("FAIL idle_q: got %b expected 0", bus.q); end
    endtask

    task automatic test_mid_reset();
        do_reset();
        bus.req = 4'b0001;
        bus.in  = 4'b1111;
        tick();
        n_checks++; if (bus.gnt !== 4'b0001) begin n_fail++; $display("FAIL midrst_pre_gnt: got %b expected 0001", bus.gnt); end
        #2;
        rst = 1'b1;
        #1;
        n_checks++; if (bus.gnt !== 4'b0000) begin n_fail++; $display("FAIL midrst_gnt: got %b expected 0000", bus.gnt); end
        n_checks++; if (bus.q !== 1'b0) begin n_fail++; $display("FAIL midrst_q: got %b expected 0", bus.q); end
        @(negedge clk);
        rst = 1'b0;
        #1;
        n_checks++; if (bus.valid !== 1'b0) begin n_fail++; $display("FAIL midrst_release_valid: got %b expected 0", bus.valid); end
        tick();
        n_checks++; if (bus.gnt !== 4'b0001) begin n_fail++; $display("FAIL midrst_regrant: got %b expected 0001", bus.gnt); end
    endtask

    initial begin
        clk      = 1'b0;
        rst      = 1'b1;
        bus.req  = 4'b0000;
        bus.in   = 4'b0000;
        n_checks = 0;
        n_fail   = 0;
        test_reset();
        test_rotation();
        test_hold_expiry();
        test_early_release();
        test_sole_requester();
        test_datapath();
        test_mid_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/mux4_rr_arbiter.md
# mux4_rr_arbiter

Round-robin arbiter and select sequencer for the 4:1 single-bit multiplexer datapath. It shares the mux output among four requesters, drives the mux select from a registered grant and presents the selected data bit with a valid flag. Each granted requester may hold the channel for a bounded number of cycles. It sits between the requesting sources and the muxer4 instance, and replaces a hand-driven `sel`.

## Interface
- `MAX_HOLD`, 4: max consecutive cycles one requester keeps the grant; legal range 1..15.
- `clk`  input  1  rising-edge clock.
- `rst`  input  1  asynchronous, active-high reset.
- `req`  input  4  request per source; bit i = source i.
- `in`  input  4  data bit per source; feeds the mux.
- `gnt`  output  4  one-hot grant, registered; all-zero when idle.
- `sel`  output  2  mux select, registered; index of the current/last owner.
- `q`  output  1  `in[sel]` when `valid`, else 0; combinational from registered `sel`/`valid`.
- `valid`  output  1  `|gnt`.

## Operation
- States: IDLE (no grant) and GRANT (one owner).
- Round-robin pointer `last` (2 bits) holds the last granted index. The search order is `last+1, last+2, last+3, last` mod 4. The first requester found in that order wins.
- IDLE:
  - Any `req` bit set: grant the winner, `last`←winner, hold counter←1, go to GRANT.
  - No request: stay in IDLE.
- GRANT, owner o:
  - `req[o]`=1 and counter < MAX_HOLD: keep the grant, counter+1.
  - `req[o]`=1 and counter = MAX_HOLD: re-arbitrate. The search order starts at o+1, so another requester wins if present. If o is the only requester, o is re-granted and the counter←1.
  - `req[o]`=0: re-arbitrate among the remaining requests. If none, go to IDLE with `gnt`=0 and `sel` unchanged.
- The hold counter is 4 bits and saturates logically at MAX_HOLD. It never wraps.
- `sel` updates only when a new grant is issued. It retains its value through IDLE.
- `in` is never registered. `q` follows `in[sel]` in the same cycle while `valid`=1.

## Timing
- Reset values (async assert, sync-safe deassert): `gnt`=0000, `sel`=00, `valid`=0, `q`=0, `last`=3, state IDLE, counter=0. The first grant therefore goes to source 0 when several request.
- Latency: `req` sampled at edge N produces `gnt`/`sel` at edge N+1, i.e. one cycle. `q` is valid in the same cycle as `gnt`.
- Handover between owners has zero dead cycles. `gnt` changes one-hot to one-hot at a single edge.
- Simultaneous owner drop and new request at edge N: the new owner is granted at edge N+1.
- `rst` asserted mid-grant: outputs clear immediately. No grant is issued until the first edge after release.
- `req` bits that assert and deassert between edges are never seen.

## Configuration
- `MUXARB_HOLD_EN` defined: hold behaviour as above, governed by MAX_HOLD.
- Not defined: MAX_HOLD is ignored and treated as 1. The block re-arbitrates every cycle, so with multiple requesters the grant rotates each cycle. The hold counter is not synthesised.

## Test plan
- Reset: assert `rst` with `req`=1111 → `gnt`=0000, `valid`=0, `q`=0. On release, first edge → `gnt`=0001, `sel`=00.
- Hold expiry (macro on, MAX_HOLD=4): `req`=0011 held steady → `gnt`=0001 for 4 cycles, then 0010 for 4 cycles, then 0001.
- Early release: owner 2 drops `req` after 2 cycles while `req[3]`=1 → `gnt`=1000 at the next edge, with no idle cycle.
- Sole requester: `req`=0100 for 10 cycles → `gnt`=0100 continuously. The counter re-arms at each expiry and `valid` never drops.
- Data path: owner 1 with `in`=0010, then `in`=1101 → `q`=1, then 0. In IDLE with `in`=1111 → `q`=0.
- Macro off: `req`=1111 → `sel` sequence 0,1,2,3,0 on consecutive cycles.
